// File: rtl/ticket_bcd_counter.sv
//------------------------------------------------------------------------------
// ticket_bcd_counter
//   Debounced inc/dec/clr push-buttons driving a saturating 3-digit BCD ticket
//   count with full/empty status and a reject pulse for refused steps.
//   Optional auto-repeat of inc/dec while held: define AUTO_REPEAT_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ticket_bcd_counter #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CAPACITY        = 999,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic       btn_clr,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic       full,
  output logic       empty,
  output logic       reject
);

  localparam int c_tmr_w = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [c_tmr_w-1:0] c_tmr_zero = '0;
  localparam logic [c_tmr_w-1:0] c_tmr_one  = c_tmr_w'(1);
  localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] c_idle   = 2'd0;
  localparam logic [1:0] c_arm    = 2'd1;
  localparam logic [1:0] c_held   = 2'd2;
  localparam logic [1:0] c_disarm = 2'd3;

  localparam logic [11:0] c_cap_bcd = {4'(CAPACITY / 100),
                                       4'((CAPACITY / 10) % 10),
                                       4'(CAPACITY % 10)};

`ifdef AUTO_REPEAT_EN
  localparam int c_rep_max = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int c_rep_w   = $clog2(c_rep_max) + 1;
  localparam logic [c_rep_w-1:0] c_rep_one      = c_rep_w'(1);
  localparam logic [c_rep_w-1:0] c_dly_last     = c_rep_w'(REPEAT_DELAY - 1);
  localparam logic [c_rep_w-1:0] c_per_last     = c_rep_w'(REPEAT_PERIOD - 1);
`endif

  if (CAPACITY < 1 || CAPACITY > 999) begin : g_bad_capacity
    $error("ticket_bcd_counter: CAPACITY must be within 1..999");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("ticket_bcd_counter: DEBOUNCE_CYCLES must be at least 2");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("ticket_bcd_counter: REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
  end

  // Button index: 0 = increment, 1 = decrement, 2 = clear
  logic [2:0] w_raw;
  logic [2:0] w_step;

  assign w_raw = {btn_clr, btn_dec, btn_inc};

  for (genvar gi = 0; gi < 3; gi++) begin : g_btn
    logic [1:0]         r_sync;
    logic [1:0]         r_state;
    logic [c_tmr_w-1:0] r_timer;
    logic               r_press;
    logic               w_s;

    assign w_s = r_sync[1];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_sync  <= 2'b00;
        r_state <= c_idle;
        r_timer <= c_tmr_zero;
        r_press <= 1'b0;
      end else begin
        r_sync  <= {r_sync[0], w_raw[gi]};
        r_press <= 1'b0;
        case (r_state)
          c_idle: begin
            if (w_s) begin
              r_state <= c_arm;
              r_timer <= c_tmr_one;
            end
          end
          c_arm: begin
            if (!w_s) begin
              r_state <= c_idle;
              r_timer <= c_tmr_zero;
            end else if (r_timer == c_tmr_last) begin
              r_state <= c_held;
              r_timer <= c_tmr_zero;
              r_press <= 1'b1;
            end else begin
              r_timer <= r_timer + c_tmr_one;
            end
          end
          c_held: begin
            if (!w_s) begin
              r_state <= c_disarm;
              r_timer <= c_tmr_one;
            end
          end
          c_disarm: begin
            if (w_s) begin
              r_state <= c_held;
              r_timer <= c_tmr_zero;
            end else if (r_timer == c_tmr_last) begin
              r_state <= c_idle;
              r_timer <= c_tmr_zero;
            end else begin
              r_timer <= r_timer + c_tmr_one;
            end
          end
          default: begin
            r_state <= c_idle;
            r_timer <= c_tmr_zero;
          end
        endcase
      end
    end

`ifdef AUTO_REPEAT_EN
    if (gi != 2) begin : g_rep
      // First repeat after the delay, then one per period while still held
      logic [c_rep_w-1:0] r_rep_cnt;
      logic               r_rep_run;
      logic               r_rep_pulse;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_rep_cnt   <= '0;
          r_rep_run   <= 1'b0;
          r_rep_pulse <= 1'b0;
        end else begin
          r_rep_pulse <= 1'b0;
          if (r_state == c_held && w_s) begin
            if (r_rep_cnt == (r_rep_run ? c_per_last : c_dly_last)) begin
              r_rep_cnt   <= '0;
              r_rep_run   <= 1'b1;
              r_rep_pulse <= 1'b1;
            end else begin
              r_rep_cnt <= r_rep_cnt + c_rep_one;
            end
          end else begin
            r_rep_cnt <= '0;
            r_rep_run <= 1'b0;
          end
        end
      end

      assign w_step[gi] = r_press | r_rep_pulse;
    end else begin : g_norep
      assign w_step[gi] = r_press;
    end
`else
    assign w_step[gi] = r_press;
`endif
  end

  logic       w_inc;
  logic       w_dec;
  logic       w_clr;
  logic [3:0] r_d0;
  logic [3:0] r_d1;
  logic [3:0] r_d2;
  logic       r_full;
  logic       r_empty;
  logic       r_reject;
  logic [3:0] w_nxt_d0;
  logic [3:0] w_nxt_d1;
  logic [3:0] w_nxt_d2;
  logic       w_refuse;
  logic       w_at_cap;
  logic       w_at_zero;
  logic       w_nxt_full;
  logic       w_nxt_empty;

  assign w_inc     = w_step[0];
  assign w_dec     = w_step[1];
  assign w_clr     = w_step[2];
  assign w_at_cap  = ({r_d2, r_d1, r_d0} == c_cap_bcd);
  assign w_at_zero = ({r_d2, r_d1, r_d0} == 12'h000);

  // Ripple carry/borrow directly on BCD digits
  always_comb begin
    w_nxt_d0 = r_d0;
    w_nxt_d1 = r_d1;
    w_nxt_d2 = r_d2;
    w_refuse = 1'b0;
    if (w_clr) begin
      w_nxt_d0 = 4'd0;
      w_nxt_d1 = 4'd0;
      w_nxt_d2 = 4'd0;
    end else if (w_inc && w_dec) begin
      w_refuse = 1'b0;
    end else if (w_inc) begin
      if (w_at_cap) begin
        w_refuse = 1'b1;
      end else if (r_d0 != 4'd9) begin
        w_nxt_d0 = r_d0 + 4'd1;
      end else begin
        w_nxt_d0 = 4'd0;
        if (r_d1 != 4'd9) begin
          w_nxt_d1 = r_d1 + 4'd1;
        end else begin
          w_nxt_d1 = 4'd0;
          w_nxt_d2 = r_d2 + 4'd1;
        end
      end
    end else if (w_dec) begin
      if (w_at_zero) begin
        w_refuse = 1'b1;
      end else if (r_d0 != 4'd0) begin
        w_nxt_d0 = r_d0 - 4'd1;
      end else begin
        w_nxt_d0 = 4'd9;
        if (r_d1 != 4'd0) begin
          w_nxt_d1 = r_d1 - 4'd1;
        end else begin
          w_nxt_d1 = 4'd9;
          w_nxt_d2 = r_d2 - 4'd1;
        end
      end
    end
  end

  assign w_nxt_full  = ({w_nxt_d2, w_nxt_d1, w_nxt_d0} == c_cap_bcd);
  assign w_nxt_empty = ({w_nxt_d2, w_nxt_d1, w_nxt_d0} == 12'h000);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d0     <= 4'd0;
      r_d1     <= 4'd0;
      r_d2     <= 4'd0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_reject <= 1'b0;
    end else begin
      r_d0     <= w_nxt_d0;
      r_d1     <= w_nxt_d1;
      r_d2     <= w_nxt_d2;
      r_full   <= w_nxt_full;
      r_empty  <= w_nxt_empty;
      r_reject <= w_refuse;
    end
  end

  assign digit0 = r_d0;
  assign digit1 = r_d1;
  assign digit2 = r_d2;
  assign full   = r_full;
  assign empty  = r_empty;
  assign reject = r_reject;

endmodule

`default_nettype wire

// File: tb/tb_ticket_bcd_counter.sv
//------------------------------------------------------------------------------
// tb_ticket_bcd_counter
//   Two counters (capacity 999 and 12) share the same buttons; a scoreboard
//   holds the expected display snapshot and cycle of every visible step.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ticket_bcd_counter;

  localparam int DEB   = 4;
  localparam int CAP_A = 999;
  localparam int CAP_B = 12;
`ifdef AUTO_REPEAT_EN
  localparam int SINGLE_HOLD = 8;
`else
  localparam int SINGLE_HOLD = 20;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_inc = 1'b0;
  logic btn_dec = 1'b0;
  logic btn_clr = 1'b0;
  logic [3:0] a_d0, a_d1, a_d2, b_d0, b_d1, b_d2;
  logic a_full, a_empty, a_rej, b_full, b_empty, b_rej;

  ticket_bcd_counter #(.DEBOUNCE_CYCLES(DEB), .CAPACITY(CAP_A),
                       .REPEAT_DELAY(10), .REPEAT_PERIOD(3)) u_dut_a (
    .clk(clk), .rst(rst), .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_clr(btn_clr),
    .digit0(a_d0), .digit1(a_d1), .digit2(a_d2),
    .full(a_full), .empty(a_empty), .reject(a_rej));

  ticket_bcd_counter #(.DEBOUNCE_CYCLES(DEB), .CAPACITY(CAP_B),
                       .REPEAT_DELAY(10), .REPEAT_PERIOD(3)) u_dut_b (
    .clk(clk), .rst(rst), .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_clr(btn_clr),
    .digit0(b_d0), .digit1(b_d1), .digit2(b_d2),
    .full(b_full), .empty(b_empty), .reject(b_rej));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [29:0] snap;
  } exp_t;

  exp_t q[$];
  int   ma = 0;
  int   mb = 0;
  int   n_pass = 0;
  int   n_total = 0;

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [29:0] model_snap(input bit ra, input bit rb);
    return {to_bcd(ma), ma == CAP_A, ma == 0, ra, to_bcd(mb), mb == CAP_B, mb == 0, rb};
  endfunction

  function automatic logic [29:0] dut_snap();
    return {a_d2, a_d1, a_d0, a_full, a_empty, a_rej, b_d2, b_d1, b_d0, b_full, b_empty, b_rej};
  endfunction

  task automatic model_step(input bit inc, input bit dec, input bit clr, input int due);
    bit ra, rb;
    int pa, pb;
    ra = 0; rb = 0; pa = ma; pb = mb;
    if (clr) begin
      ma = 0; mb = 0;
    end else if (inc && dec) begin
      ra = 0;
    end else if (inc) begin
      if (ma == CAP_A) ra = 1; else ma++;
      if (mb == CAP_B) rb = 1; else mb++;
    end else if (dec) begin
      if (ma == 0) ra = 1; else ma--;
      if (mb == 0) rb = 1; else mb--;
    end
    if (ma != pa || mb != pb || ra || rb) q.push_back('{due, model_snap(ra, rb)});
  endtask

  task automatic press(input bit inc, input bit dec, input bit clr, input int hold);
    @(negedge clk);
    btn_inc = inc; btn_dec = dec; btn_clr = clr;
    model_step(inc, dec, clr, cyc + DEB + 3);
    repeat (hold) @(negedge clk);
    btn_inc = 0; btn_dec = 0; btn_clr = 0;
    repeat (12) @(negedge clk);
  endtask

  // Scoreboard consumer: every visible output event must match the queue head
  initial begin
    logic [29:0] cur;
    logic [27:0] st, prev;
    exp_t        e;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = dut_snap();
      st  = {cur[29:16], cur[14:1]};
      if (rst) begin
        prev = st;
      end else if (st !== prev || cur[15] || cur[0]) begin
        prev = st;
        n_total++;
        if (q.size() == 0) begin
          $display("FAIL unexpected_event cyc=%0d actual=%h required=no change", cyc, cur);
        end else begin
          e = q.pop_front();
          if (cur !== e.snap || cyc != e.due)
            $display("FAIL scoreboard actual=%h@%0d required=%h@%0d", cur, cyc, e.snap, e.due);
          else
            n_pass++;
        end
      end
    end
  end

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_total++;
    if ({a_d2, a_d1, a_d0, a_full, a_empty, a_rej} !== {12'h000, 3'b010})
      $display("FAIL reset_a_in actual=%h required=%h", {a_d2, a_d1, a_d0, a_full, a_empty, a_rej}, {12'h000, 3'b010});
    else n_pass++;
    #2 rst = 0;
    ma = 0; mb = 0;
    @(negedge clk);
    n_total++;
    if ({a_d2, a_d1, a_d0, a_full, a_empty, a_rej} !== {12'h000, 3'b010})
      $display("FAIL reset_a actual=%h required=%h", {a_d2, a_d1, a_d0, a_full, a_empty, a_rej}, {12'h000, 3'b010});
    else n_pass++;
    n_total++;
    if ({b_d2, b_d1, b_d0, b_full, b_empty, b_rej} !== {12'h000, 3'b010})
      $display("FAIL reset_b actual=%h required=%h", {b_d2, b_d1, b_d0, b_full, b_empty, b_rej}, {12'h000, 3'b010});
    else n_pass++;
  endtask

  task automatic test_single_inc();
    int c;
    @(negedge clk);
    c = cyc;
    btn_inc = 1;
    model_step(1, 0, 0, c + DEB + 3);
    repeat (DEB + 2) @(negedge clk);
    n_total++;
    if ({a_d2, a_d1, a_d0, a_empty} !== {12'h000, 1'b1})
      $display("FAIL early_step actual=%h required=%h", {a_d2, a_d1, a_d0, a_empty}, {12'h000, 1'b1});
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({a_d2, a_d1, a_d0, a_empty} !== {12'h001, 1'b0})
      $display("FAIL first_step actual=%h required=%h", {a_d2, a_d1, a_d0, a_empty}, {12'h001, 1'b0});
    else n_pass++;
    repeat (SINGLE_HOLD - DEB - 3) @(negedge clk);
    btn_inc = 0;
    repeat (12) @(negedge clk);
    n_total++;
    if ({a_d2, a_d1, a_d0} !== to_bcd(ma))
      $display("FAIL one_step_per_press actual=%h required=%h", {a_d2, a_d1, a_d0}, to_bcd(ma));
    else n_pass++;
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      btn_inc = ((i / 2) % 2) == 0;
    end
    @(negedge clk);
    btn_inc = 0;
    repeat (12) @(negedge clk);
    n_total++;
    if ({a_d2, a_d1, a_d0, b_d2, b_d1, b_d0} !== {to_bcd(ma), to_bcd(mb)})
      $display("FAIL bounce actual=%h required=%h", {a_d2, a_d1, a_d0, b_d2, b_d1, b_d0}, {to_bcd(ma), to_bcd(mb)});
    else n_pass++;
  endtask

  task automatic test_carry();
    press(0, 0, 1, 8);
    for (int i = 0; i < 99; i++) press(1, 0, 0, 8);
    n_total++;
    if ({a_d2, a_d1, a_d0, b_d2, b_d1, b_d0, b_full} !== {12'h099, 12'h012, 1'b1})
      $display("FAIL count_099 actual=%h required=%h", {a_d2, a_d1, a_d0, b_d2, b_d1, b_d0, b_full}, {12'h099, 12'h012, 1'b1});
    else n_pass++;
    press(1, 0, 0, 8);
    n_total++;
    if ({a_d2, a_d1, a_d0} !== 12'h100)
      $display("FAIL carry_100 actual=%h required=%h", {a_d2, a_d1, a_d0}, 12'h100);
    else n_pass++;
    press(0, 1, 0, 8);
    n_total++;
    if ({a_d2, a_d1, a_d0, b_d2, b_d1, b_d0} !== {12'h099, 12'h011})
      $display("FAIL borrow_099 actual=%h required=%h", {a_d2, a_d1, a_d0, b_d2, b_d1, b_d0}, {12'h099, 12'h011});
    else n_pass++;
  endtask

  task automatic test_saturation();
    press(1, 0, 0, 8);
    press(1, 0, 0, 8);
    n_total++;
    if ({b_d2, b_d1, b_d0, b_full, b_rej} !== {12'h012, 2'b10})
      $display("FAIL hold_at_full actual=%h required=%h", {b_d2, b_d1, b_d0, b_full, b_rej}, {12'h012, 2'b10});
    else n_pass++;
    press(0, 0, 1, 8);
    press(0, 1, 0, 8);
    n_total++;
    if ({a_empty, b_empty, a_d2, a_d1, a_d0} !== {2'b11, 12'h000})
      $display("FAIL hold_at_empty actual=%h required=%h", {a_empty, b_empty, a_d2, a_d1, a_d0}, {2'b11, 12'h000});
    else n_pass++;
  endtask

  task automatic test_aligned();
    for (int i = 0; i < 5; i++) press(1, 0, 0, 8);
    press(1, 1, 0, 8);
    n_total++;
    if ({a_d2, a_d1, a_d0, a_rej} !== {12'h005, 1'b0})
      $display("FAIL inc_dec_aligned actual=%h required=%h", {a_d2, a_d1, a_d0, a_rej}, {12'h005, 1'b0});
    else n_pass++;
    press(1, 0, 1, 8);
    n_total++;
    if ({a_d2, a_d1, a_d0, b_d2, b_d1, b_d0} !== 24'h000000)
      $display("FAIL clr_priority actual=%h required=%h", {a_d2, a_d1, a_d0, b_d2, b_d1, b_d0}, 24'h000000);
    else n_pass++;
  endtask

  task automatic test_reset_mid_arm();
    int d;
    press(1, 0, 0, 8);
    press(1, 0, 0, 8);
    @(negedge clk);
    btn_inc = 1;
    repeat (4) @(negedge clk);
    #2 rst = 1;
    ma = 0; mb = 0;
    repeat (2) @(negedge clk);
    #2 rst = 0;
    d = cyc;
    model_step(1, 0, 0, d + DEB + 3);
    repeat (DEB + 2) @(negedge clk);
    n_total++;
    if ({a_d2, a_d1, a_d0, a_empty} !== {12'h000, 1'b1})
      $display("FAIL rst_discard actual=%h required=%h", {a_d2, a_d1, a_d0, a_empty}, {12'h000, 1'b1});
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({a_d2, a_d1, a_d0} !== 12'h001)
      $display("FAIL fresh_debounce actual=%h required=%h", {a_d2, a_d1, a_d0}, 12'h001);
    else n_pass++;
    btn_inc = 0;
    repeat (12) @(negedge clk);
  endtask

`ifdef AUTO_REPEAT_EN
  task automatic test_repeat();
    int c;
    press(0, 0, 1, 8);
    @(negedge clk);
    c = cyc;
    btn_inc = 1;
    model_step(1, 0, 0, c + DEB + 3);
    for (int k = 0; k < 6; k++) model_step(1, 0, 0, c + DEB + 13 + 3 * k);
    repeat (DEB + 27) @(negedge clk);
    btn_inc = 0;
    repeat (12) @(negedge clk);
    n_total++;
    if ({a_d2, a_d1, a_d0} !== 12'h007)
      $display("FAIL repeat_steps actual=%h required=%h", {a_d2, a_d1, a_d0}, 12'h007);
    else n_pass++;
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_inc();
    test_bounce();
    test_carry();
    test_saturation();
    test_aligned();
    test_reset_mid_arm();
`ifdef AUTO_REPEAT_EN
    test_repeat();
`endif
    repeat (4) @(negedge clk);
    n_total++;
    if (q.size() != 0)
      $display("FAIL scoreboard_drain actual=%0d pending required=0", q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
